// File: rtl/rx_block_lock_pkg.sv
// Shared definitions for the 64b/66b receive block-lock logic:
// sync header encodings, lock FSM states and the header validity helper.
package rx_block_lock_pkg;

    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    typedef enum logic [1:0] {
        TEST      = 2'b00,
        SLIP      = 2'b01,
        SLIP_HOLD = 2'b10
    } lock_state_t;

    // Only the two transition patterns are legal sync headers; 00 and 11 are not.
    function automatic logic sh_is_valid(input logic [1:0] sh);
        return (sh == SYNC_DATA) || (sh == SYNC_CTRL);
    endfunction

endpackage

// File: rtl/rx_block_lock_if.sv
// Header stream from the RX gearbox and the block-lock status returned to it and the PCS.
interface rx_block_lock_if;
    import rx_block_lock_pkg::*;

    logic        header_valid;
    logic [1:0]  header;
    logic        slip;
    logic        block_lock;
    logic        lock_lost;
    logic [15:0] slip_count;

    modport master (
        output header_valid,
        output header,
        input  slip,
        input  block_lock,
        input  lock_lost,
        input  slip_count
    );

    modport slave (
        input  header_valid,
        input  header,
        output slip,
        output block_lock,
        output lock_lost,
        output slip_count
    );

endinterface

// File: rtl/rx_block_lock.sv
// 64b/66b block-lock FSM: counts sync headers per test window, requests gearbox
// slips until the block boundary is found, and reports lock to the PCS decoder.
module rx_block_lock
    import rx_block_lock_pkg::*;
#(
    parameter int SH_CNT_MAX   = 64,
    parameter int SH_INVLD_MAX = 16,
    parameter int SLIP_WAIT    = 32
) (
    input  logic         xver_rxc,
    input  logic         rx_reset_n,
    input  logic         srst,
    rx_block_lock_if.slave rx
);

    localparam int CNT_W  = $clog2(SH_CNT_MAX + 1);
    localparam int INV_W  = $clog2(SH_INVLD_MAX + 1);
    localparam int WAIT_W = $clog2(SLIP_WAIT + 1);

    lock_state_t         state_r;
    lock_state_t         state_s;
    logic [CNT_W-1:0]    sh_cnt_r;
    logic [CNT_W-1:0]    sh_cnt_s;
    logic [CNT_W-1:0]    sh_cnt_inc_s;
    logic [INV_W-1:0]    sh_invld_cnt_r;
    logic [INV_W-1:0]    sh_invld_cnt_s;
    logic [INV_W-1:0]    sh_invld_inc_s;
    logic [WAIT_W-1:0]   wait_cnt_r;
    logic [WAIT_W-1:0]   wait_cnt_s;
    logic                header_bad_s;
    logic                slip_r;
    logic                slip_s;
    logic                block_lock_r;
    logic                block_lock_s;
    logic                lock_lost_r;
    logic                lock_lost_s;
    logic [15:0]         slip_count_r;
    logic [15:0]         slip_count_s;

    assign header_bad_s   = !sh_is_valid(rx.header);
    assign sh_cnt_inc_s   = sh_cnt_r + CNT_W'(1);
    assign sh_invld_inc_s = sh_invld_cnt_r + {{(INV_W-1){1'b0}}, header_bad_s};

    // Next-state, counter and output decisions for the lock FSM.
    always_comb begin
        state_s        = state_r;
        sh_cnt_s       = sh_cnt_r;
        sh_invld_cnt_s = sh_invld_cnt_r;
        wait_cnt_s     = wait_cnt_r;
        block_lock_s   = block_lock_r;
        slip_s         = 1'b0;
        lock_lost_s    = 1'b0;
        slip_count_s   = slip_count_r;
        case (state_r)
            TEST: begin
                if (rx.header_valid) begin
                    // Too many errors in the window outranks the window-end rule.
                    if (header_bad_s && (!block_lock_r ||
                        (sh_invld_inc_s == INV_W'(SH_INVLD_MAX)))) begin
                        state_s        = SLIP;
                        sh_cnt_s       = {CNT_W{1'b0}};
                        sh_invld_cnt_s = {INV_W{1'b0}};
                        slip_s         = 1'b1;
                        block_lock_s   = 1'b0;
                        lock_lost_s    = block_lock_r;
                        if (slip_count_r != 16'hFFFF) begin
                            slip_count_s = slip_count_r + 16'd1;
                        end else begin
                            slip_count_s = slip_count_r;
                        end
                    end else if (sh_cnt_inc_s == CNT_W'(SH_CNT_MAX)) begin
                        sh_cnt_s       = {CNT_W{1'b0}};
                        sh_invld_cnt_s = {INV_W{1'b0}};
                        if (sh_invld_inc_s == {INV_W{1'b0}}) begin
                            block_lock_s = 1'b1;
                        end else begin
                            block_lock_s = block_lock_r;
                        end
                    end else begin
                        sh_cnt_s       = sh_cnt_inc_s;
                        sh_invld_cnt_s = sh_invld_inc_s;
                    end
                end else begin
                    state_s = TEST;
                end
            end
            SLIP: begin
                state_s    = SLIP_HOLD;
                wait_cnt_s = WAIT_W'(SLIP_WAIT);
            end
            SLIP_HOLD: begin
                wait_cnt_s = wait_cnt_r - WAIT_W'(1);
                if (wait_cnt_s == {WAIT_W{1'b0}}) begin
                    state_s = TEST;
                end else begin
                    state_s = SLIP_HOLD;
                end
            end
            default: begin
                state_s        = TEST;
                sh_cnt_s       = {CNT_W{1'b0}};
                sh_invld_cnt_s = {INV_W{1'b0}};
                wait_cnt_s     = {WAIT_W{1'b0}};
                block_lock_s   = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs; hard reset is async, soft reset sync.
    always_ff @(posedge xver_rxc or negedge rx_reset_n) begin
        if (!rx_reset_n) begin
            state_r        <= TEST;
            sh_cnt_r       <= {CNT_W{1'b0}};
            sh_invld_cnt_r <= {INV_W{1'b0}};
            wait_cnt_r     <= {WAIT_W{1'b0}};
            slip_r         <= 1'b0;
            block_lock_r   <= 1'b0;
            lock_lost_r    <= 1'b0;
            slip_count_r   <= 16'd0;
        end else if (srst) begin
            state_r        <= TEST;
            sh_cnt_r       <= {CNT_W{1'b0}};
            sh_invld_cnt_r <= {INV_W{1'b0}};
            wait_cnt_r     <= {WAIT_W{1'b0}};
            slip_r         <= 1'b0;
            block_lock_r   <= 1'b0;
            lock_lost_r    <= 1'b0;
            slip_count_r   <= 16'd0;
        end else begin
            state_r        <= state_s;
            sh_cnt_r       <= sh_cnt_s;
            sh_invld_cnt_r <= sh_invld_cnt_s;
            wait_cnt_r     <= wait_cnt_s;
            slip_r         <= slip_s;
            block_lock_r   <= block_lock_s;
            lock_lost_r    <= lock_lost_s;
            slip_count_r   <= slip_count_s;
        end
    end

    assign rx.slip       = slip_r;
    assign rx.block_lock = block_lock_r;
    assign rx.lock_lost  = lock_lost_r;
    assign rx.slip_count = slip_count_r;

endmodule

// File: tb/tb_rx_block_lock.sv
// Scoreboard bench for rx_block_lock: a window-level reference model predicts the
// outputs after every sampled cycle; a monitor compares them one cycle at a time.
module tb_rx_block_lock;

    localparam int SH_CNT_MAX   = 64;
    localparam int SH_INVLD_MAX = 16;
    localparam int SLIP_WAIT    = 32;

    typedef struct packed {
        logic        slip;
        logic        lock;
        logic        lost;
        logic [15:0] cnt;
    } exp_t;

    logic clk;
    logic rst_n;
    logic srst;
    rx_block_lock_if bus ();

    rx_block_lock #(
        .SH_CNT_MAX  (SH_CNT_MAX),
        .SH_INVLD_MAX(SH_INVLD_MAX),
        .SLIP_WAIT   (SLIP_WAIT)
    ) dut (
        .xver_rxc  (clk),
        .rx_reset_n(rst_n),
        .srst      (srst),
        .rx        (bus)
    );

    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];

    // Reference model: position in the current window, errors seen, headers still to ignore.
    bit   m_lock;
    int   m_cnt;
    int   m_inv;
    int   m_ignore;
    int   m_slips;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Monitor: one prediction per sampled cycle, checked just after the edge.
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a.slip = bus.slip;
                a.lock = bus.block_lock;
                a.lost = bus.lock_lost;
                a.cnt  = bus.slip_count;
                tests++;
                if (a !== e) begin
                    fails++;
                    $display("FAIL cycle_outputs @%0t: actual slip=%b lock=%b lost=%b cnt=%0d required slip=%b lock=%b lost=%b cnt=%0d",
                             $time, a.slip, a.lock, a.lost, a.cnt, e.slip, e.lock, e.lost, e.cnt);
                end
            end
        end
    end

    task automatic model_reset();
        m_lock = 1'b0; m_cnt = 0; m_inv = 0; m_ignore = 0; m_slips = 0;
    endtask

    task automatic model_step(input logic hv, input logic [1:0] h, output bit slipped);
        exp_t e;
        bit   bad;
        bit   lost;
        slipped = 1'b0;
        lost    = 1'b0;
        if (m_ignore > 0) begin
            m_ignore--;
        end else if (hv) begin
            bad = (h == 2'b00) || (h == 2'b11);
            m_cnt++;
            if (bad) m_inv++;
            if (bad && (!m_lock || m_inv == SH_INVLD_MAX)) begin
                slipped  = 1'b1;
                lost     = m_lock;
                m_lock   = 1'b0;
                m_cnt    = 0;
                m_inv    = 0;
                m_ignore = SLIP_WAIT + 1;
                if (m_slips < 65535) m_slips++;
            end else if (m_cnt == SH_CNT_MAX) begin
                if (m_inv == 0) m_lock = 1'b1;
                m_cnt = 0;
                m_inv = 0;
            end
        end
        e.slip = slipped;
        e.lock = m_lock;
        e.lost = lost;
        e.cnt  = m_slips[15:0];
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic hv, input logic [1:0] h, output bit slipped);
        @(negedge clk);
        bus.header_valid = hv;
        bus.header       = h;
        model_step(hv, h, slipped);
    endtask

    task automatic drive_n(input logic hv, input logic [1:0] h);
        bit s;
        drive(hv, h, s);
    endtask

    function automatic logic [1:0] good_sh();
        return ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
    endfunction

    function automatic logic [1:0] bad_sh();
        return ($urandom_range(0, 1) == 1) ? 2'b00 : 2'b11;
    endfunction

    // Let the last driven header be sampled and checked, then idle the inputs.
    task automatic settle();
        @(posedge clk);
        #2;
        bus.header_valid = 1'b0;
    endtask

    task automatic hard_reset(input string tag);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        bus.header_valid = 1'b0;
        #1;
        check({tag, "_slip"},  {31'd0, bus.slip},       32'd0);
        check({tag, "_lock"},  {31'd0, bus.block_lock}, 32'd0);
        check({tag, "_lost"},  {31'd0, bus.lock_lost},  32'd0);
        check({tag, "_count"}, {16'd0, bus.slip_count}, 32'd0);
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic clean_window();
        for (int i = 0; i < SH_CNT_MAX; i++) drive_n(1'b1, good_sh());
    endtask

    // A window of 64 headers carrying exactly k invalid ones at random spots.
    task automatic window_with_errors(input int k);
        bit bad_pos[SH_CNT_MAX];
        int placed;
        int p;
        for (int i = 0; i < SH_CNT_MAX; i++) bad_pos[i] = 1'b0;
        placed = 0;
        while (placed < k) begin
            p = $urandom_range(0, SH_CNT_MAX - 1);
            if (!bad_pos[p]) begin
                bad_pos[p] = 1'b1;
                placed++;
            end
        end
        for (int i = 0; i < SH_CNT_MAX; i++) drive_n(1'b1, bad_pos[i] ? bad_sh() : good_sh());
    endtask

    // Serial 66b stream: block header followed by 64 pseudo-random payload bits.
    function automatic logic stream_bit(input longint unsigned pos);
        longint unsigned b;
        longint unsigned idx;
        logic [63:0]     x;
        logic [1:0]      sh;
        b   = pos / 66;
        idx = pos % 66;
        x   = b * 64'h9E3779B97F4A7C15;
        sh  = x[37] ? 2'b10 : 2'b01;
        if (idx == 0) begin
            return sh[0];
        end else if (idx == 1) begin
            return sh[1];
        end else begin
            x = pos * 64'hD1B54A32D192ED03;
            x = x ^ (x >> 29);
            return x[33];
        end
    endfunction

    function automatic logic [1:0] gb_header(input longint unsigned blk, input int off);
        longint unsigned pos;
        logic [1:0] h;
        pos  = blk * 66 + longint'(off);
        h[0] = stream_bit(pos);
        h[1] = stream_bit(pos + 1);
        return h;
    endfunction

    initial begin
        bit              s;
        int              off;
        int              guard;
        int              slips_at_lock;
        longint unsigned blk;

        rst_n = 1'b0;
        srst  = 1'b0;
        bus.header_valid = 1'b0;
        bus.header       = 2'b00;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Alternating data/control headers from reset reach lock after 64.
        for (int i = 0; i < SH_CNT_MAX; i++) drive_n(1'b1, (i % 2 == 0) ? 2'b01 : 2'b10);
        drive_n(1'b1, 2'b01);
        settle();
        check("t1_locked", {31'd0, bus.block_lock}, 32'd1);
        check("t1_no_slips", {16'd0, bus.slip_count}, 32'd0);

        // Unlocked: 5th header bad slips; the following 33 bad headers are ignored.
        hard_reset("t2_rst");
        for (int i = 0; i < 4; i++) drive_n(1'b1, good_sh());
        drive_n(1'b1, 2'b11);
        for (int i = 0; i < SLIP_WAIT + 1; i++) drive_n(1'b1, bad_sh());
        drive_n(1'b1, 2'b00);
        drive_n(1'b1, good_sh());
        settle();
        check("t2_slip_count", {16'd0, bus.slip_count}, 32'd2);

        // Locked: 15 errors per window held, 16 errors slip.
        hard_reset("t3_rst");
        clean_window();
        window_with_errors(SH_INVLD_MAX - 1);
        window_with_errors(SH_INVLD_MAX - 1);
        settle();
        check("t3_lock_held_15", {31'd0, bus.block_lock}, 32'd1);
        window_with_errors(SH_INVLD_MAX);
        for (int i = 0; i < SLIP_WAIT + 2; i++) drive_n(1'b1, good_sh());
        settle();
        check("t3_lock_dropped_16", {31'd0, bus.block_lock}, 32'd0);

        // Locked: 63 valid + 1 invalid keeps lock; a clean window follows.
        hard_reset("t4_rst");
        clean_window();
        for (int i = 0; i < SH_CNT_MAX - 1; i++) drive_n(1'b1, good_sh());
        drive_n(1'b1, bad_sh());
        clean_window();
        settle();
        check("t4_lock_kept", {31'd0, bus.block_lock}, 32'd1);
        check("t4_no_slip", {16'd0, bus.slip_count}, 32'd0);

        // Gearbox 7 bits off: slip until aligned, then 1000 clean blocks.
        hard_reset("t5_rst");
        off   = 7;
        blk   = 0;
        guard = 0;
        while (!m_lock && guard < 20000) begin
            drive(1'b1, gb_header(blk, off), s);
            if (s) off = (off + 1) % 66;
            blk++;
            guard++;
        end
        settle();
        check("t5_locked", {31'd0, bus.block_lock}, 32'd1);
        check("t5_slips_le_66", {31'd0, (bus.slip_count <= 16'd66)}, 32'd1);
        slips_at_lock = m_slips;
        for (int i = 0; i < 1000; i++) begin
            drive(1'b1, gb_header(blk, off), s);
            if (s) off = (off + 1) % 66;
            blk++;
        end
        settle();
        check("t5_no_more_slips", {16'd0, bus.slip_count}, slips_at_lock);
        check("t5_still_locked", {31'd0, bus.block_lock}, 32'd1);

        // Reset while o_slip is high, during slip hold, and mid-window.
        hard_reset("t6_rst_a");
        drive_n(1'b1, bad_sh());
        hard_reset("t6_rst_during_slip");
        drive_n(1'b1, bad_sh());
        for (int i = 0; i < 10; i++) drive_n(1'b1, good_sh());
        hard_reset("t6_rst_in_hold");
        clean_window();
        for (int i = 0; i < 30; i++) drive_n(1'b1, good_sh());
        hard_reset("t6_rst_mid_window");

        // Gaps never advance the window: lock comes after exactly 64 valid headers.
        for (int i = 0; i < SH_CNT_MAX; i++) begin
            for (int g = $urandom_range(0, 3); g > 0; g--) drive_n(1'b0, bad_sh());
            drive_n(1'b1, good_sh());
        end
        for (int i = 0; i < 200; i++) drive_n(1'b0, bad_sh());
        settle();
        check("t6_gaps_lock", {31'd0, bus.block_lock}, 32'd1);

        // Soft reset clears everything on the next edge.
        @(negedge clk);
        srst = 1'b1;
        bus.header_valid = 1'b1;
        bus.header       = 2'b11;
        @(posedge clk);
        #2;
        check("srst_lock", {31'd0, bus.block_lock}, 32'd0);
        check("srst_count", {16'd0, bus.slip_count}, 32'd0);
        model_reset();
        @(negedge clk);
        srst = 1'b0;
        bus.header_valid = 1'b0;

        // Random traffic: gaps, occasional error bursts.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 4) == 0) drive_n(1'b0, bad_sh());
            else if ($urandom_range(0, (i % 1000 < 500) ? 60 : 4) == 0) drive_n(1'b1, bad_sh());
            else drive_n(1'b1, good_sh());
        end
        settle();
        repeat (2) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
